fdiv_seq: RTL

- Parametrised multi-cycle IEEE-754 single-precision divider/reciprocal unit for the FPU.
- Successor to the fixed fdiv. Adds configurable quotient bits per cycle, a reciprocal mode (inv), a tag passthrough, and exact round-to-nearest-even.
- Sits beside fadd/fmul in the FPU execute stage.
- Uses an en/busy/done handshake with fixed latency, so the issue logic can schedule writeback.

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fdiv_seq_if.sv | 29 ++
 rtl/fdiv_qstep.sv | 33 +++
 rtl/fdiv_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// fpu_pkg : shared IEEE-754 single-precision fields, constants, classify
// rev 1.0
// ----------------------------------------------------------------------
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;
    localparam logic [31:0] ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fclass_t;

    // Denormals are grouped with zero: the FPU runs flush-to-zero.
    function automatic fclass_t classify(input logic [31:0] x);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        fclass_t           c;
        e = x[FRAC_W +: EXP_W];
        f = x[FRAC_W-1:0];
        c = NORM;
        if (e == '0)
            c = ZERO;
        else if (e == '1)
            c = (f != '0) ? NAN : INF;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fdiv_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// fdiv_seq_if : issue/result bundle of the sequential divider
// rev 1.0
// ----------------------------------------------------------------------
interface fdiv_seq_if #(
    parameter int TAG_W = 5
);
    logic             en;
    logic             inv;
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag_in;
    logic [31:0]      y;
    logic [TAG_W-1:0] tag_out;
    logic             done;
    logic             busy;

    modport master (
        output en, inv, x1, x2, tag_in,
        input  y, tag_out, done, busy
    );

    modport slave (
        input  en, inv, x1, x2, tag_in,
        output y, tag_out, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/fdiv_qstep.sv
`default_nettype none
// ----------------------------------------------------------------------
// fdiv_qstep : QBITS chained restoring-division steps (combinational)
// rev 1.0
// ----------------------------------------------------------------------
module fdiv_qstep #(
    parameter int QBITS = 1
) (
    input  logic [24:0]      rem,
    input  logic [23:0]      divisor,
    output logic [QBITS-1:0] q,
    output logic [24:0]      rem_next
);

    logic [24:0] w_chain [0:QBITS];

    assign w_chain[0] = rem;

    for (genvar i = 0; i < QBITS; i++) begin : g_step
        logic        w_ge;
        logic [23:0] w_diff;

        assign w_ge   = w_chain[i] >= {1'b0, divisor};
        // A partial remainder below the divisor always fits in 24 bits.
        assign w_diff = w_ge ? 24'(w_chain[i] - {1'b0, divisor}) : w_chain[i][23:0];
        assign q[QBITS-1-i]  = w_ge;
        assign w_chain[i+1]  = {w_diff, 1'b0};
    end

    assign rem_next = w_chain[QBITS];

endmodule
`default_nettype wire

// File: rtl/fdiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------
// fdiv_seq : fixed-latency IEEE-754 single divide / reciprocal with RNE
// rev 1.0
// ----------------------------------------------------------------------
module fdiv_seq
    import fpu_pkg::*;
#(
    parameter int QBITS = 1,
    parameter int TAG_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    fdiv_seq_if.slave  bus
);

    localparam int ITER  = (25 + QBITS - 1) / QBITS;
    localparam int QW    = ITER * QBITS;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ROUND = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [31:0]         r_y;
    logic [TAG_W-1:0]    r_tag_out;
    logic [TAG_W-1:0]    r_tag;
    logic                r_sign;
    logic                r_special;
    logic [31:0]         r_special_val;
    logic [EXP_W-1:0]    r_ea;
    logic [EXP_W-1:0]    r_eb;
    logic [23:0]         r_ma;
    logic [23:0]         r_mb;
    logic                r_align;
    logic [24:0]         r_rem;
    logic [QW-1:0]       r_q;
    logic signed [9:0]   r_exp;
    logic [CNT_W-1:0]    r_cnt;

    // Operand capture and special-case decision
    logic [31:0] w_a;
    fclass_t     w_ca;
    fclass_t     w_cb;
    logic        w_sign;
    logic        w_special;
    logic [31:0] w_special_val;

    assign w_a    = bus.inv ? ONE : bus.x1;
    assign w_ca   = classify(w_a);
    assign w_cb   = classify(bus.x2);
    assign w_sign = w_a[31] ^ bus.x2[31];

    always_comb begin
        w_special     = 1'b1;
        w_special_val = '0;
        if (w_ca == NAN || w_cb == NAN || (w_ca == ZERO && w_cb == ZERO) ||
            (w_ca == INF && w_cb == INF))
            w_special_val = QNAN;
        else if (w_cb == ZERO || w_ca == INF)
            w_special_val = {w_sign, PINF[30:0]};
        else if (w_cb == INF || w_ca == ZERO)
            w_special_val = {w_sign, 31'b0};
        else
            w_special = 1'b0;
    end

    // Iteration datapath
    logic [QBITS-1:0] w_qbits;
    logic [24:0]      w_rem_next;
    logic             w_ma_lt;

    fdiv_qstep #(.QBITS(QBITS)) u_qstep (
        .rem      (r_rem),
        .divisor  (r_mb),
        .q        (w_qbits),
        .rem_next (w_rem_next)
    );

    assign w_ma_lt = r_ma < r_mb;

    // Normalise and round: the top 25 quotient bits are significand + guard
    logic [24:0]       w_q25;
    logic              w_sticky;
    logic              w_inc;
    logic [24:0]       w_sig_rnd;
    logic              w_carry;
    logic signed [9:0] w_exp_fin;
    logic [31:0]       w_norm_y;

    assign w_q25     = r_q[QW-1 -: 25];
    assign w_sticky  = (|(r_q << 25)) || (|r_rem);
    assign w_inc     = w_q25[0] && (w_sticky || w_q25[1]);
    assign w_sig_rnd = {1'b0, w_q25[24:1]} + 25'(w_inc);
    assign w_carry   = w_sig_rnd[24];
    assign w_exp_fin = r_exp + $signed({9'b0, w_carry});

    always_comb begin
        w_norm_y = {r_sign, w_exp_fin[7:0], w_sig_rnd[22:0]};
        if (w_exp_fin >= 10'sd255)
            w_norm_y = {r_sign, PINF[30:0]};
        else if (w_exp_fin <= 10'sd0)
            w_norm_y = {r_sign, 31'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_y           <= '0;
            r_tag_out     <= '0;
            r_tag         <= '0;
            r_sign        <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_ea          <= '0;
            r_eb          <= '0;
            r_ma          <= '0;
            r_mb          <= '0;
            r_align       <= 1'b0;
            r_rem         <= '0;
            r_q           <= '0;
            r_exp         <= '0;
            r_cnt         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // busy stays high through the done cycle, so en there is dropped
                    r_busy <= 1'b0;
                    if (bus.en && !r_busy) begin
                        r_busy        <= 1'b1;
                        r_tag         <= bus.tag_in;
                        r_sign        <= w_sign;
                        r_special     <= w_special;
                        r_special_val <= w_special_val;
                        r_ea          <= w_a[FRAC_W +: EXP_W];
                        r_eb          <= bus.x2[FRAC_W +: EXP_W];
                        r_ma          <= {1'b1, w_a[FRAC_W-1:0]};
                        r_mb          <= {1'b1, bus.x2[FRAC_W-1:0]};
                        r_align       <= 1'b1;
                        r_q           <= '0;
                        r_cnt         <= CNT_W'(ITER);
                        r_state       <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_align) begin
                        // Pre-shift so the quotient lands in [1,2)
                        r_align <= 1'b0;
                        r_rem   <= w_ma_lt ? {r_ma, 1'b0} : {1'b0, r_ma};
                        r_exp   <= $signed({2'b0, r_ea}) - $signed({2'b0, r_eb})
                                   + 10'(BIAS) - (w_ma_lt ? 10'sd1 : 10'sd0);
                    end else begin
                        r_rem <= w_rem_next;
                        r_q   <= {r_q[QW-QBITS-1:0], w_qbits};
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1))
                            r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_y       <= r_special ? r_special_val : w_norm_y;
                    r_tag_out <= r_tag;
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.y       = r_y;
    assign bus.tag_out = r_tag_out;
    assign bus.done    = r_done;
    assign bus.busy    = r_busy;

endmodule
`default_nettype wire
